// File: rtl/csa_accumulator.sv
// Resolves carry-save product pairs and accumulates one frame of signed products per result.
// Build option: define CSA_ACC_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module csa_accumulator #(
  parameter int N     = 17,
  parameter int M     = 17,
  parameter int GUARD = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [N+M-1:0]           in1,
  input  logic [N+M-1:0]           in2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N+M+GUARD-1:0]     out_sum,
  output logic [CNT_W-1:0]         out_count,
  output logic                     out_ovf
);

  localparam int W     = N + M;
  localparam int ACC_W = W + GUARD;

  typedef enum logic [1:0] {S_ACC, S_FLUSH, S_OUT} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       p_reg_q, p_reg_d;
  logic               p_vld_q, p_vld_d;
  logic               p_last_q, p_last_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;

  logic               accept;
  logic [ACC_W-1:0]   p_ext;
  logic [ACC_W-1:0]   add_raw;
  logic [ACC_W-1:0]   acc_add;
  logic               ovf_now;
  logic [CNT_W-1:0]   count_inc;

  assign in_ready  = (state_q == S_ACC);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  // Accumulator adder with signed-overflow detection and optional clamping.
  always_comb begin
    p_ext     = ACC_W'($signed(p_reg_q));
    add_raw   = acc_q + p_ext;
    ovf_now   = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) && (add_raw[ACC_W-1] != acc_q[ACC_W-1]);
    acc_add   = add_raw;
`ifdef CSA_ACC_SAT_EN
    if (ovf_now) begin
      acc_add = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
    count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    p_reg_d     = p_reg_q;
    p_vld_d     = accept;
    p_last_d    = p_last_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (accept) begin
      p_reg_d  = in1 + in2;
      p_last_d = in_last;
    end

    if (p_vld_q) begin
      acc_d   = acc_add;
      count_d = count_inc;
      ovf_d   = ovf_q | ovf_now;
    end

    case (state_q)
      S_ACC: begin
        if (accept && in_last) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        // Results capture the post-add values of the frame's final product.
        if (p_vld_q && p_last_q) begin
          out_sum_d   = acc_d;
          out_count_d = count_d;
          out_ovf_d   = ovf_d;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          count_d     = '0;
          ovf_d       = 1'b0;
          state_d     = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_ACC;
      p_reg_q     <= '0;
      p_vld_q     <= 1'b0;
      p_last_q    <= 1'b0;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_reg_q     <= p_reg_d;
      p_vld_q     <= p_vld_d;
      p_last_q    <= p_last_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule
